nibble_uart_tx: RTL
===================

NIBBLE_UART_TX -- requirements
Module: nibble_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clk cycles per serial bit-time; legal range 2..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits new frames to start when high.
REQ-006 fifo_empty  input  1  empty flag from the upstream 4-bit FIFO.
REQ-007 fifo_q  input  4  FIFO read data; valid the cycle after a pop.
REQ-008 fifo_pop  output  1  one-cycle pop strobe to the FIFO.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 frame_cnt  output  8  count of completed frames.

Function
REQ-012 The FSM SHALL have states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-013 IDLE -> POP on a clock edge where enable=1 and fifo_empty=0; otherwise remain in IDLE.
REQ-014 fifo_pop SHALL be a registered output, high for exactly the one cycle the FSM is in POP, and low at all other times.
REQ-015 POP -> LOAD unconditionally; LOAD captures fifo_q into a 4-bit shift register, then goes to START.
REQ-016 START drives tx=0 for CLKS_PER_BIT cycles, beginning in the first cycle of START.
REQ-017 DATA drives the 4 captured bits LSB first, each for CLKS_PER_BIT cycles, using a 2-bit bit index and a bit-time counter sized for 255.
REQ-018 After DATA: PARITY if PARITY_EN=1, else STOP; PARITY drives the XOR of the 4 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-019 STOP drives tx=1 for CLKS_PER_BIT cycles, then returns to IDLE.
REQ-020 frame_cnt SHALL increment by 1 on the edge leaving STOP; it wraps from 255 to 0.
REQ-021 tx SHALL be registered, glitch-free, and 1 in IDLE, POP and LOAD.
REQ-022 Exactly one pop per frame; a second pop SHALL NOT occur before the current frame's STOP completes.
REQ-023 fifo_empty and enable are sampled only in IDLE; deasserting enable mid-frame lets the frame complete; fifo_empty changes mid-frame are ignored.
REQ-024 Spacing between consecutive pop pulses with a continuously non-empty FIFO SHALL be 3 + N*CLKS_PER_BIT cycles, with N = 7 (parity) or 6 (no parity).
REQ-025 busy = 1 in every state except IDLE.

Reset
REQ-026 While reset=1 at a clock edge: state=IDLE, tx=1, fifo_pop=0, busy=0, frame_cnt=0, shift register and counters=0.
REQ-027 Reset SHALL override all other inputs.
REQ-028 Reset mid-frame SHALL abandon the frame and SHALL NOT re-pop the lost nibble.
REQ-029 After reset deasserts, the first pop SHALL occur no earlier than the second edge following deassertion (IDLE -> POP).

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=1, one nibble 4'hA queued -> one pop pulse, then tx = 0,0,1,0,1,0,1 in 4-cycle segments (start, d0..d3, parity=0, stop=1); frame_cnt 0->1; busy drops after the stop bit.
REQ-031 PARITY_EN=0, nibble 4'h7 -> tx segments 0,1,1,1,0,1; six bit-times total; frame_cnt=1.
REQ-032 fifo_empty held 1 or enable held 0 for 100 cycles -> fifo_pop never asserts; tx=1; busy=0.
REQ-033 CLKS_PER_BIT=4, PARITY_EN=1, two nibbles queued -> exactly two pop pulses, 31 cycles apart; frame_cnt=2.
REQ-034 Reset asserted during DATA bit 2 -> the next cycle shows tx=1, busy=0, fifo_pop=0, frame_cnt=0; no pop until two edges after deassertion.
REQ-035 256 back-to-back frames -> frame_cnt returns to 0; enable dropped mid-frame 257 -> that frame completes and no further pop occurs.

Source files
------------

// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: pops 4-bit nibbles from an upstream FIFO and sends each
// as a start / 4 data (LSB first) / optional even parity / stop frame.
module nibble_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [3:0] fifo_q,
   output logic       fifo_pop,
   output logic       tx,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

   state_e     state_q;
   logic [3:0] shift_q;
   logic       par_q;
   logic [1:0] bit_idx_q;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       bit_done;
   logic       tx_q;
   logic       pop_q;
   logic       busy_q;
   logic [7:0] frame_cnt_q;

   // Bit-time counter wraps to zero at the end of every serial bit.
   assign bit_done = (cnt_q == BIT_LAST);
   assign cnt_d    = bit_done ? 8'd0 : cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= 4'd0;
         par_q       <= 1'b0;
         bit_idx_q   <= 2'd0;
         cnt_q       <= 8'd0;
         tx_q        <= 1'b1;
         pop_q       <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (enable && !fifo_empty) begin
                  state_q <= POP;
                  pop_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            POP: begin
               pop_q   <= 1'b0;
               state_q <= LOAD;
            end
            LOAD: begin
               // FIFO data is valid in the cycle after the pop strobe.
               shift_q   <= fifo_q;
               par_q     <= ^fifo_q;
               cnt_q     <= 8'd0;
               bit_idx_q <= 2'd0;
               tx_q      <= 1'b0;
               state_q   <= START;
            end
            START: begin
               cnt_q <= cnt_d;
               if (bit_done) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_d;
               if (bit_done) begin
                  bit_idx_q <= bit_idx_q + 2'd1;
                  shift_q   <= {1'b0, shift_q[3:1]};
                  if (bit_idx_q == 2'd3) begin
                     if (PARITY_EN) begin
                        tx_q    <= par_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end
            end
            PARITY: begin
               cnt_q <= cnt_d;
               if (bit_done) begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end
            end
            STOP: begin
               cnt_q <= cnt_d;
               if (bit_done) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               pop_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_pop  = pop_q;
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign frame_cnt = frame_cnt_q;

endmodule
